// File: rtl/clk_negedge_ser_tx_if.sv
// Handshake and serial-side bundle for clk_negedge_ser_tx.
// The master side feeds words in. The slave side is the transmitter itself.
interface clk_negedge_ser_tx_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              ser_out;
  logic              ser_frame;
  logic              ser_sof;
  logic              busy;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  ser_out,
    input  ser_frame,
    input  ser_sof,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output ser_out,
    output ser_frame,
    output ser_sof,
    output busy
  );
endinterface

// File: rtl/clk_negedge_ser_tx.sv
// Parallel-to-serial transmitter. Words are accepted on posedge into a 1-entry hold buffer.
// Bits are launched on negedge, so a rising-edge receiver samples each bit mid-eye.
module clk_negedge_ser_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  clk_negedge_ser_tx_if.slave   bus
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  // Posedge domain
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              take_seen_q, take_seen_d;

  // Negedge domain
  state_e            state_q, state_d;
  logic              take_tgl_q, take_tgl_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_frame_q, ser_frame_d;
  logic              ser_sof_q, ser_sof_d;

  logic take_pend;
  logic in_ready;
  logic accept;
  logic ld_ok;
  logic cnt_zero;

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  // The toggle pair hands "word taken" from the negedge side back to the posedge side.
  assign take_pend = take_tgl_q ^ take_seen_q;
  assign in_ready  = !hold_valid_q | take_pend;
  assign accept    = bus.in_valid & in_ready;
  assign ld_ok     = hold_valid_q & !take_pend;
  assign cnt_zero  = (bit_cnt_q == '0);

  // ---------------------------------------------------------------------------
  // Posedge side: hold buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    take_seen_d  = take_seen_q;
    if (take_pend) begin
      take_seen_d  = take_tgl_q;
      hold_valid_d = 1'b0;
    end
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      take_seen_q  <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      take_seen_q  <= take_seen_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Negedge side: FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ld_ok) state_d = StShift;
      StShift: if (cnt_zero && !ld_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath logic. A reload at the last bit keeps the frame gapless.
  always_comb begin
    shreg_d     = shreg_q;
    take_tgl_d  = take_tgl_q;
    bit_cnt_d   = '0;
    ser_out_d   = 1'b0;
    ser_frame_d = 1'b0;
    ser_sof_d   = 1'b0;
    if (ld_ok && ((state_q == StIdle) || cnt_zero)) begin
      shreg_d     = hold_data_q;
      take_tgl_d  = ~take_tgl_q;
      bit_cnt_d   = CntW'(DATA_W - 1);
      ser_out_d   = first_bit(hold_data_q);
      ser_frame_d = 1'b1;
      ser_sof_d   = 1'b1;
    end else if ((state_q == StShift) && !cnt_zero) begin
      shreg_d     = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
      bit_cnt_d   = bit_cnt_q - CntW'(1);
      ser_out_d   = first_bit(shreg_d);
      ser_frame_d = 1'b1;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      take_tgl_q  <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      ser_out_q   <= 1'b0;
      ser_frame_q <= 1'b0;
      ser_sof_q   <= 1'b0;
    end else begin
      take_tgl_q  <= take_tgl_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_out_q   <= ser_out_d;
      ser_frame_q <= ser_frame_d;
      ser_sof_q   <= ser_sof_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_frame = ser_frame_q;
  assign bus.ser_sof   = ser_sof_q;
  assign bus.busy      = ser_frame_q | hold_valid_q;

endmodule

// File: tb/tb_clk_negedge_ser_tx.sv
// Scoreboard bench for clk_negedge_ser_tx: an MSB-first 8-bit build, an LSB-first 8-bit
// build and an LSB-first 4-bit build share one clock and reset.
module tb_clk_negedge_ser_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  clk_negedge_ser_tx_if #(.DATA_W(8)) bus_a ();
  clk_negedge_ser_tx_if #(.DATA_W(8)) bus_l ();
  clk_negedge_ser_tx_if #(.DATA_W(4)) bus_n ();

  clk_negedge_ser_tx #(.DATA_W(8), .MSB_FIRST(1'b1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  clk_negedge_ser_tx #(.DATA_W(8), .MSB_FIRST(1'b0)) u_dut_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l)
  );

  clk_negedge_ser_tx #(.DATA_W(4), .MSB_FIRST(1'b0)) u_dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit exp_q[3][$];
  bit sof_q[3][$];
  int popped[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input int id, input logic [7:0] d, input int w, input bit msb);
    for (int i = 0; i < w; i++) begin
      exp_q[id].push_back(msb ? d[w-1-i] : d[i]);
      sof_q[id].push_back(i == 0);
    end
  endtask

  // Compare one receiver sample (taken just after posedge) against the scoreboard.
  task automatic mon(input int id, input logic out, input logic frame, input logic sof);
    if (frame === 1'b1) begin
      if (exp_q[id].size() == 0) begin
        chk($sformatf("extra_bit_dut%0d", id), frame, 1'b0);
      end else begin
        chk($sformatf("bit_dut%0d_n%0d", id, popped[id]), out, exp_q[id].pop_front());
        chk($sformatf("sof_dut%0d_n%0d", id, popped[id]), sof, sof_q[id].pop_front());
        popped[id]++;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, bus_a.ser_out, bus_a.ser_frame, bus_a.ser_sof);
    mon(1, bus_l.ser_out, bus_l.ser_frame, bus_l.ser_sof);
    mon(2, bus_n.ser_out, bus_n.ser_frame, bus_n.ser_sof);
  end

  // Hold in_valid until accepted; in_ready is stable from negedge to the next posedge.
  task automatic send_a(input logic [7:0] d, output int stalls);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    stalls = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      #1;
      if (bus_a.in_ready) break;
      stalls++;
    end
    chk("send_ready", bus_a.in_ready, 1'b1);
    push_word(0, d, 8, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int id, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q[id].size() == 0) break;
      @(posedge clk);
      #2;
    end
    chk($sformatf("drain_dut%0d", id), exp_q[id].size(), 0);
  endtask

  int s;
  int base;

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_data = '0;
    bus_l.in_valid = 1'b0; bus_l.in_data = '0;
    bus_n.in_valid = 1'b0; bus_n.in_data = '0;

    // 1. Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ser_out",   bus_a.ser_out,   1'b0);
    chk("rst_ser_frame", bus_a.ser_frame, 1'b0);
    chk("rst_ser_sof",   bus_a.ser_sof,   1'b0);
    chk("rst_busy",      bus_a.busy,      1'b0);
    chk("rst_in_ready",  bus_a.in_ready,  1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2. Single word, MSB first
    send_a(8'hA5, s);
    chk("t2_stall", s, 0);
    bus_a.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t2_frame_p%0d", k + 1), bus_a.ser_frame, 1'b1);
      chk($sformatf("t2_busy_p%0d", k + 1), bus_a.busy, 1'b1);
    end
    @(posedge clk); #1;
    chk("t2_frame_p9", bus_a.ser_frame, 1'b0);
    chk("t2_busy_p9",  bus_a.busy,      1'b0);

    // 3. Back-to-back, gapless
    send_a(8'h3C, s);
    send_a(8'hC3, s);
    chk("t3_second_stall", s, 0);
    bus_a.in_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t3_frame_p%0d", k + 2), bus_a.ser_frame, 1'b1);
    end
    @(posedge clk); #1;
    chk("t3_frame_end", bus_a.ser_frame, 1'b0);
    chk("t3_busy_end",  bus_a.busy,      1'b0);

    // 4. Backpressure with three words offered continuously
    base = popped[0];
    send_a(8'h5A, s);
    send_a(8'h96, s);
    chk("t4_w2_stall", s, 0);
    send_a(8'h0F, s);
    chk("t4_w3_stall", s, 7);
    bus_a.in_valid = 1'b0;
    drain(0, 100);
    @(posedge clk); #1;
    chk("t4_bit_count", popped[0] - base, 24);
    chk("t4_frame_end", bus_a.ser_frame, 1'b0);
    chk("t4_busy_end",  bus_a.busy,      1'b0);

    // 5. Reset mid-frame after three bits
    send_a(8'hF0, s);
    bus_a.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_frame", bus_a.ser_frame, 1'b0);
    chk("t5_rst_out",   bus_a.ser_out,   1'b0);
    chk("t5_rst_sof",   bus_a.ser_sof,   1'b0);
    chk("t5_rst_busy",  bus_a.busy,      1'b0);
    chk("t5_rst_ready", bus_a.in_ready,  1'b1);
    exp_q[0].delete();
    sof_q[0].delete();
    #20 rst_n = 1'b1;
    #1;
    chk("t5_ready_after", bus_a.in_ready, 1'b1);
    @(posedge clk); #1;
    base = popped[0];
    send_a(8'hFF, s);
    bus_a.in_valid = 1'b0;
    drain(0, 40);
    @(posedge clk); #1;
    chk("t5_ff_count", popped[0] - base, 8);
    chk("t5_frame_end", bus_a.ser_frame, 1'b0);

    // 6. LSB-first builds: 8-bit 8'h01 and 4-bit 4'hA
    bus_l.in_valid = 1'b1; bus_l.in_data = 8'h01;
    bus_n.in_valid = 1'b1; bus_n.in_data = 4'hA;
    chk("t6_l_ready", bus_l.in_ready, 1'b1);
    chk("t6_n_ready", bus_n.in_ready, 1'b1);
    push_word(1, 8'h01, 8, 1'b0);
    push_word(2, 8'h0A, 4, 1'b0);
    @(posedge clk); #1;
    bus_l.in_valid = 1'b0;
    bus_n.in_valid = 1'b0;
    drain(1, 40);
    drain(2, 40);
    @(posedge clk); #1;
    chk("t6_l_count", popped[1], 8);
    chk("t6_n_count", popped[2], 4);
    chk("t6_l_frame_end", bus_l.ser_frame, 1'b0);
    chk("t6_n_busy_end",  bus_n.busy,      1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
